// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS core: default field widths,
// the hardwired zero register, control-bundle bit offsets and stage update modes.
package cpu_pkg;

    localparam int PC_W         = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int REG_W_DEF    = 5;
    localparam int TNEW_W_DEF   = 2;
    localparam int CTRL_W_DEF   = 8;

    localparam int ZERO_REG     = 0;

    // Bit positions inside the opaque control bundle, shared by every stage.
    localparam int CTRL_REGMEM   = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_JAL      = 3;
    localparam int CTRL_JR       = 4;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_ALUSRC   = 6;
    localparam int CTRL_SIGNEXT  = 7;

    typedef enum logic [1:0] {
        UPD_RESET,
        UPD_FLUSH,
        UPD_HOLD,
        UPD_LOAD
    } upd_e;

endpackage

// File: rtl/fwd_match.sv
// Compares one source-register query against the destination held in a
// pipeline stage and reports a forwarding hit and whether it must stall.
module fwd_match
    import cpu_pkg::*;
#(
    parameter int REG_W  = REG_W_DEF,
    parameter int TNEW_W = TNEW_W_DEF
) (
    input  logic              valid,
    input  logic              regwrite,
    input  logic [REG_W-1:0]  writereg,
    input  logic [TNEW_W-1:0] tnew,
    input  logic [REG_W-1:0]  query,
    output logic              hit,
    output logic              stall
);

    // $0 is hardwired to zero, so a write to it never produces a value to forward.
    assign hit   = valid & regwrite & (writereg != REG_W'(ZERO_REG)) & (writereg == query);
    assign stall = hit & (tnew != '0);

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall/flush, Tnew countdown,
// forwarding-hit detection against the held destination and a bubble counter.
module pipe_stage_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int TNEW_W = TNEW_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int NQ     = 2,
    parameter int CNT_W  = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Stall,
    input  logic                Flush,
    input  logic                Valid_In,
    input  logic [PC_W-1:0]     Pc_In,
    input  logic [CTRL_W-1:0]   Ctrl_In,
    input  logic [DATA_W-1:0]   Data_In,
    input  logic [REG_W-1:0]    WriteReg_In,
    input  logic                RegWrite_In,
    input  logic [TNEW_W-1:0]   Tnew_In,
    input  logic [NQ*REG_W-1:0] Query_Reg,
    output logic                Valid_Out,
    output logic [PC_W-1:0]     Pc_Out,
    output logic [CTRL_W-1:0]   Ctrl_Out,
    output logic [DATA_W-1:0]   Data_Out,
    output logic [REG_W-1:0]    WriteReg_Out,
    output logic                RegWrite_Out,
    output logic [TNEW_W-1:0]   Tnew_Out,
    output logic [NQ-1:0]       Fwd_Hit,
    output logic [NQ-1:0]       Fwd_Stall,
    output logic [CNT_W-1:0]    Bubble_Cnt
);

    upd_e              upd;
    logic [TNEW_W-1:0] tnew_dec;

    always_comb begin
        if (Reset)      upd = UPD_RESET;
        else if (Flush) upd = UPD_FLUSH;
        else if (Stall) upd = UPD_HOLD;
        else            upd = UPD_LOAD;
    end

    // Tnew counts down by one per stage and stops at zero rather than wrapping.
    assign tnew_dec = (Tnew_In == '0) ? '0 : Tnew_In - TNEW_W'(1);

    // NOTE: state registers use non-blocking assignments so every field samples
    // the pre-edge values together, independent of statement order.
    always_ff @(posedge Clk) begin
        unique case (upd)
            UPD_RESET: begin
                Valid_Out    <= 1'b0;
                Pc_Out       <= '0;
                Ctrl_Out     <= '0;
                Data_Out     <= '0;
                WriteReg_Out <= '0;
                RegWrite_Out <= 1'b0;
                Tnew_Out     <= '0;
            end
            UPD_FLUSH: begin
                // The PC survives a flush so EPC/delay-slot tracking still sees it.
                Valid_Out    <= 1'b0;
                Pc_Out       <= Pc_In;
                Ctrl_Out     <= '0;
                Data_Out     <= '0;
                WriteReg_Out <= '0;
                RegWrite_Out <= 1'b0;
                Tnew_Out     <= '0;
            end
            UPD_HOLD: begin
            end
            UPD_LOAD: begin
                Valid_Out    <= Valid_In;
                Pc_Out       <= Pc_In;
                Ctrl_Out     <= Valid_In ? Ctrl_In : '0;
                Data_Out     <= Data_In;
                WriteReg_Out <= WriteReg_In;
                RegWrite_Out <= Valid_In & RegWrite_In;
                Tnew_Out     <= Valid_In ? tnew_dec : '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            Bubble_Cnt <= '0;
        else if (!Valid_Out && (Bubble_Cnt != '1))
            Bubble_Cnt <= Bubble_Cnt + CNT_W'(1);
    end

    for (genvar i = 0; i < NQ; i++) begin : g_fwd
        fwd_match #(
            .REG_W  (REG_W),
            .TNEW_W (TNEW_W)
        ) u_fwd_match (
            .valid    (Valid_Out),
            .regwrite (RegWrite_Out),
            .writereg (WriteReg_Out),
            .tnew     (Tnew_Out),
            .query    (Query_Reg[i*REG_W +: REG_W]),
            .hit      (Fwd_Hit[i]),
            .stall    (Fwd_Stall[i])
        );
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default instance plus a 3-bit-counter
// instance sharing the same stimulus for the bubble saturation case.
module tb_pipe_stage_reg;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Flush, Valid_In, RegWrite_In;
    logic [31:0] Pc_In, Data_In;
    logic [7:0]  Ctrl_In;
    logic [4:0]  WriteReg_In;
    logic [1:0]  Tnew_In;
    logic [9:0]  Query_Reg;

    logic        Valid_Out, RegWrite_Out;
    logic [31:0] Pc_Out, Data_Out;
    logic [7:0]  Ctrl_Out;
    logic [4:0]  WriteReg_Out;
    logic [1:0]  Tnew_Out, Fwd_Hit, Fwd_Stall;
    logic [15:0] Bubble_Cnt;

    logic        s_valid, s_regwrite;
    logic [31:0] s_pc, s_data;
    logic [7:0]  s_ctrl;
    logic [4:0]  s_writereg;
    logic [1:0]  s_tnew, s_hit, s_stall;
    logic [2:0]  s_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    pipe_stage_reg dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .Valid_In(Valid_In),
        .Pc_In(Pc_In), .Ctrl_In(Ctrl_In), .Data_In(Data_In), .WriteReg_In(WriteReg_In),
        .RegWrite_In(RegWrite_In), .Tnew_In(Tnew_In), .Query_Reg(Query_Reg),
        .Valid_Out(Valid_Out), .Pc_Out(Pc_Out), .Ctrl_Out(Ctrl_Out), .Data_Out(Data_Out),
        .WriteReg_Out(WriteReg_Out), .RegWrite_Out(RegWrite_Out), .Tnew_Out(Tnew_Out),
        .Fwd_Hit(Fwd_Hit), .Fwd_Stall(Fwd_Stall), .Bubble_Cnt(Bubble_Cnt)
    );

    pipe_stage_reg #(.CNT_W(3)) dut_small (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .Valid_In(Valid_In),
        .Pc_In(Pc_In), .Ctrl_In(Ctrl_In), .Data_In(Data_In), .WriteReg_In(WriteReg_In),
        .RegWrite_In(RegWrite_In), .Tnew_In(Tnew_In), .Query_Reg(Query_Reg),
        .Valid_Out(s_valid), .Pc_Out(s_pc), .Ctrl_Out(s_ctrl), .Data_Out(s_data),
        .WriteReg_Out(s_writereg), .RegWrite_Out(s_regwrite), .Tnew_Out(s_tnew),
        .Fwd_Hit(s_hit), .Fwd_Stall(s_stall), .Bubble_Cnt(s_cnt)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [7:0] ctrl,
                         input logic [31:0] data, input logic [4:0] wr, input logic rw,
                         input logic [1:0] tn);
        Valid_In = v; Pc_In = pc; Ctrl_In = ctrl; Data_In = data;
        WriteReg_In = wr; RegWrite_In = rw; Tnew_In = tn;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Stall = 1'b1; Flush = 1'b1;
        drive(1'b1, '1, '1, '1, '1, 1'b1, '1);
        Query_Reg = '1;
        tick();
        tick();
        n_tests++;
        if ({Valid_Out, Pc_Out, Ctrl_Out, Data_Out, WriteReg_Out, RegWrite_Out, Tnew_Out} !== '0) begin
            $display("FAIL reset_regs actual valid=%0b pc=%h ctrl=%h data=%h wr=%0d rw=%0b tnew=%0d required all 0",
                     Valid_Out, Pc_Out, Ctrl_Out, Data_Out, WriteReg_Out, RegWrite_Out, Tnew_Out);
            n_fail++;
        end
        n_tests++;
        if ({Fwd_Hit, Fwd_Stall} !== 4'b0) begin
            $display("FAIL reset_fwd actual hit=%b stall=%b required 00/00", Fwd_Hit, Fwd_Stall);
            n_fail++;
        end
        n_tests++;
        if (Bubble_Cnt !== 16'd0 || s_cnt !== 3'd0) begin
            $display("FAIL reset_bubble actual %0d/%0d required 0/0", Bubble_Cnt, s_cnt);
            n_fail++;
        end
    endtask

    task automatic test_load();
        Reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
        drive(1'b1, 32'h0000_0400, 8'hA5, 32'hDEAD_BEEF, 5'd8, 1'b1, 2'd2);
        Query_Reg = {5'd9, 5'd8};
        tick();
        n_tests++;
        if ({Valid_Out, Pc_Out, Ctrl_Out, Data_Out, WriteReg_Out, RegWrite_Out, Tnew_Out} !==
            {1'b1, 32'h0000_0400, 8'hA5, 32'hDEAD_BEEF, 5'd8, 1'b1, 2'd1}) begin
            $display("FAIL load_fields actual pc=%h ctrl=%h data=%h wr=%0d tnew=%0d required 400/a5/deadbeef/8/1",
                     Pc_Out, Ctrl_Out, Data_Out, WriteReg_Out, Tnew_Out);
            n_fail++;
        end
        n_tests++;
        if (Fwd_Hit !== 2'b01 || Fwd_Stall !== 2'b01) begin
            $display("FAIL load_fwd actual hit=%b stall=%b required 01/01", Fwd_Hit, Fwd_Stall);
            n_fail++;
        end
        // Query change alone must move the hit vector without a clock edge.
        Query_Reg = {5'd8, 5'd8};
        #1;
        n_tests++;
        if (Fwd_Hit !== 2'b11 || Fwd_Stall !== 2'b11) begin
            $display("FAIL query_comb actual hit=%b stall=%b required 11/11", Fwd_Hit, Fwd_Stall);
            n_fail++;
        end
        Tnew_In = 2'd0;
        tick();
        n_tests++;
        if (Tnew_Out !== 2'd0 || Fwd_Hit !== 2'b11 || Fwd_Stall !== 2'b00) begin
            $display("FAIL tnew_zero actual tnew=%0d hit=%b stall=%b required 0/11/00", Tnew_Out, Fwd_Hit, Fwd_Stall);
            n_fail++;
        end
        Tnew_In = 2'd3;
        tick();
        n_tests++;
        if (Tnew_Out !== 2'd2) begin
            $display("FAIL tnew_three actual %0d required 2", Tnew_Out);
            n_fail++;
        end
    endtask

    task automatic test_stall_flush();
        Query_Reg = {5'd9, 5'd8};
        drive(1'b1, 32'h0000_0100, 8'h3C, 32'hDEAD_BEEF, 5'd8, 1'b1, 2'd2);
        tick();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0000_0200 + 32'(i), 8'h11, 32'h0000_0000 + 32'(i), 5'd3, 1'b0, 2'd3);
            tick();
            n_tests++;
            if ({Valid_Out, Pc_Out, Ctrl_Out, Data_Out, WriteReg_Out, RegWrite_Out, Tnew_Out, Fwd_Stall} !==
                {1'b1, 32'h0000_0100, 8'h3C, 32'hDEAD_BEEF, 5'd8, 1'b1, 2'd1, 2'b01}) begin
                $display("FAIL stall_hold_%0d actual pc=%h data=%h wr=%0d tnew=%0d fstall=%b required 100/deadbeef/8/1/01",
                         i, Pc_Out, Data_Out, WriteReg_Out, Tnew_Out, Fwd_Stall);
                n_fail++;
            end
        end
        Flush = 1'b1;
        drive(1'b1, 32'h0000_0300, 8'hFF, 32'h1234_5678, 5'd8, 1'b1, 2'd2);
        tick();
        n_tests++;
        if ({Valid_Out, Pc_Out, Ctrl_Out, Data_Out, WriteReg_Out, RegWrite_Out, Tnew_Out, Fwd_Hit} !==
            {1'b0, 32'h0000_0300, 8'h00, 32'h0, 5'd0, 1'b0, 2'd0, 2'b00}) begin
            $display("FAIL flush_over_stall actual valid=%0b pc=%h ctrl=%h data=%h rw=%0b hit=%b required 0/300/0/0/0/00",
                     Valid_Out, Pc_Out, Ctrl_Out, Data_Out, RegWrite_Out, Fwd_Hit);
            n_fail++;
        end
        Flush = 1'b0; Stall = 1'b0;
        drive(1'b1, 32'h0000_0304, 8'h42, 32'h0000_0055, 5'd9, 1'b1, 2'd1);
        tick();
        n_tests++;
        if (Pc_Out !== 32'h0000_0304 || Data_Out !== 32'h55 || Tnew_Out !== 2'd0 ||
            Fwd_Hit !== 2'b10 || Fwd_Stall !== 2'b00) begin
            $display("FAIL stall_release actual pc=%h data=%h tnew=%0d hit=%b stall=%b required 304/55/0/10/00",
                     Pc_Out, Data_Out, Tnew_Out, Fwd_Hit, Fwd_Stall);
            n_fail++;
        end
    endtask

    task automatic test_zero_reg_invalid();
        drive(1'b1, 32'h0000_0500, 8'h01, 32'h0000_00AA, 5'd0, 1'b1, 2'd2);
        Query_Reg = {5'd0, 5'd0};
        tick();
        n_tests++;
        if (RegWrite_Out !== 1'b1 || Fwd_Hit !== 2'b00 || Fwd_Stall !== 2'b00) begin
            $display("FAIL zero_reg actual rw=%0b hit=%b stall=%b required 1/00/00", RegWrite_Out, Fwd_Hit, Fwd_Stall);
            n_fail++;
        end
        drive(1'b0, 32'h0000_0600, 8'hFF, 32'h0000_1234, 5'd8, 1'b1, 2'd3);
        Query_Reg = {5'd8, 5'd8};
        tick();
        n_tests++;
        if ({Valid_Out, Pc_Out, Ctrl_Out, Data_Out, WriteReg_Out, RegWrite_Out, Tnew_Out, Fwd_Hit} !==
            {1'b0, 32'h0000_0600, 8'h00, 32'h0000_1234, 5'd8, 1'b0, 2'd0, 2'b00}) begin
            $display("FAIL invalid_load actual valid=%0b pc=%h ctrl=%h data=%h rw=%0b tnew=%0d hit=%b required 0/600/0/1234/0/0/00",
                     Valid_Out, Pc_Out, Ctrl_Out, Data_Out, RegWrite_Out, Tnew_Out, Fwd_Hit);
            n_fail++;
        end
    endtask

    task automatic test_bubble_cnt();
        drive(1'b1, 32'h0000_0700, 8'h07, 32'h0000_0077, 5'd4, 1'b1, 2'd1);
        tick();
        Reset = 1'b1; Stall = 1'b1;
        tick();
        n_tests++;
        if (Valid_Out !== 1'b0 || Pc_Out !== 32'h0 || Bubble_Cnt !== 16'd0 || s_cnt !== 3'd0) begin
            $display("FAIL reset_over_stall actual valid=%0b pc=%h cnt=%0d/%0d required 0/0/0/0",
                     Valid_Out, Pc_Out, Bubble_Cnt, s_cnt);
            n_fail++;
        end
        Reset = 1'b0; Stall = 1'b0;
        Valid_In = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_tests++;
            if (Bubble_Cnt !== 16'(i) || s_cnt !== 3'((i > 7) ? 7 : i)) begin
                $display("FAIL bubble_%0d actual %0d/%0d required %0d/%0d",
                         i, Bubble_Cnt, s_cnt, i, (i > 7) ? 7 : i);
                n_fail++;
            end
        end
        Valid_In = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (Valid_Out !== 1'b1 || Bubble_Cnt !== 16'd11 || s_cnt !== 3'd7) begin
                $display("FAIL bubble_freeze_%0d actual valid=%0b cnt=%0d/%0d required 1/11/7",
                         i, Valid_Out, Bubble_Cnt, s_cnt);
                n_fail++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall_flush();
        test_zero_reg_invalid();
        test_bubble_cnt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised inter-stage pipeline register for the five-stage MIPS core. It replaces the per-stage fixed registers (D/E, E/M, M/W) and adds:
- stall (hold), flush (bubble insert) and a valid bit;
- saturating Tnew countdown;
- per-query forwarding-hit and forwarding-stall detection against the held destination register;
- a saturating bubble-cycle counter for performance debug.

Parameters:
DATA_W, 32, width of the result/data payload (ALU result or memory read data)
REG_W, 5, register-number width
TNEW_W, 2, Tnew field width
CTRL_W, 8, width of the opaque control-signal bundle (RegMem, MemtoReg, Jal, ...)
NQ, 2, number of forwarding query ports (rs, rt)
CNT_W, 16, bubble counter width

Ports:
Clk  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Stall  in  1  hold all stage contents this cycle
Flush  in  1  replace stage contents with a bubble this cycle
Valid_In  in  1  upstream slot holds a real instruction
Pc_In  in  32  instruction PC
Ctrl_In  in  CTRL_W  control bundle
Data_In  in  DATA_W  data payload
WriteReg_In  in  REG_W  destination register number
RegWrite_In  in  1  instruction writes the register file
Tnew_In  in  TNEW_W  cycles until result ready, as seen by the previous stage
Query_Reg  in  NQ*REG_W  source register numbers to check; slice i = [i*REG_W +: REG_W]
Valid_Out  out  1  registered valid
Pc_Out  out  32  registered PC
Ctrl_Out  out  CTRL_W  registered control
Data_Out  out  DATA_W  registered data; also the forwarding value
WriteReg_Out  out  REG_W  registered destination
RegWrite_Out  out  1  registered write enable
Tnew_Out  out  TNEW_W  registered, decremented Tnew
Fwd_Hit  out  NQ  query i matches a live destination
Fwd_Stall  out  NQ  query i matches, but the result is not yet ready
Bubble_Cnt  out  CNT_W  saturating count of cycles with Valid_Out=0

Behaviour:
- Update priority per rising edge: Reset > Flush > Stall > Load.
- Reset: every output register cleared to 0, including Pc_Out and Bubble_Cnt. Fwd_Hit and Fwd_Stall are therefore 0 from the next cycle.
- Flush (bubble):
  - Valid_Out, Ctrl_Out, Data_Out, WriteReg_Out, RegWrite_Out and Tnew_Out are set to 0.
  - Pc_Out loads Pc_In, kept for EPC/delay-slot tracking.
- Stall without Flush: all registers hold, including Tnew_Out (no decrement).
- Load:
  - All fields capture their inputs.
  - Tnew_Out = (Tnew_In == 0) ? 0 : Tnew_In - 1. Saturates at 0 and never wraps.
  - If Valid_In = 0: RegWrite_Out, Ctrl_Out and Tnew_Out are forced to 0; Pc_Out and Data_Out are still captured.
- Latency: one cycle from input to output in Load. Outputs are purely registered.
- Forwarding logic (combinational from registered state only, no input-to-output path):
  - Fwd_Hit[i] = Valid_Out & RegWrite_Out & (WriteReg_Out != 0) & (WriteReg_Out == Query_Reg[i]).
  - Fwd_Stall[i] = Fwd_Hit[i] & (Tnew_Out != 0).
  - Register $0 never hits.
- Bubble_Cnt:
  - Reset clears it to 0.
  - Otherwise it increments each cycle in which the current Valid_Out = 0.
  - It saturates at all-ones and holds there. Counting is independent of Stall/Flush.
- Simultaneous events:
  - Flush+Stall: flush wins.
  - Reset during Stall or Flush: reset wins.
  - Stall released: the next edge loads normally.

Decomposition:
- Shared package (cpu_pkg): TNEW_W, REG_W, DATA_W defaults; ZERO_REG = 0; the CTRL bundle field-offset constants used by all stages.
- One sub-module, fwd_match: a single query comparator (inputs: valid, regwrite, writereg, tnew, query; outputs: hit, stall). It is instantiated NQ times via generate.

Test Plan:
1. Reset=1 for 2 cycles, inputs at all-ones -> all outputs 0, Fwd_Hit=00, Bubble_Cnt=0.
2. Load with Valid_In=1, WriteReg_In=8, RegWrite_In=1, Tnew_In=2, Data_In=0xDEADBEEF, Query_Reg={9,8} -> next cycle: Tnew_Out=1, Data_Out=0xDEADBEEF, Fwd_Hit=01, Fwd_Stall=01. Reload with Tnew_In=0 -> Tnew_Out=0, Fwd_Stall=00.
3. Loaded state from scenario 2, then Stall=1 for 3 cycles while inputs change -> all outputs unchanged, Tnew_Out stays 1. Stall=1 with Flush=1 together -> bubble: Valid_Out=0, RegWrite_Out=0, Pc_Out=Pc_In.
4. WriteReg_In=0, RegWrite_In=1, Query_Reg={0,0} -> Fwd_Hit=00. Valid_In=0 with RegWrite_In=1 -> RegWrite_Out=0, Fwd_Hit=00.
5. CNT_W forced to 3, Valid_In=0 for 10 cycles -> Bubble_Cnt reaches 7 and holds at 7. A valid load then freezes the count while Valid_Out=1.
